// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush scheduler for a 5-stage pipeline.
// Resolves load-use hazards, taken-branch redirects, multi-cycle memory
// waits and multi-cycle mul/div ops into per-register hold and bubble
// controls. It also keeps a saturating stall-cycle counter and a sticky
// memory-timeout flag.
module pipeline_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             MemRead_EX,
  input  logic [4:0]       WriteRegAddr_EX,
  input  logic [4:0]       Rs_ID,
  input  logic [4:0]       Rt_ID,
  input  logic             UsesRs_ID,
  input  logic             UsesRt_ID,
  input  logic             BranchTaken_EX,
  input  logic             MemReq_MEM,
  input  logic             MemReady,
  input  logic             MulDivStart_EX,
  input  logic             MulDivDone,
  output logic             Stall_PC,
  output logic             Stall_IFID,
  output logic             Stall_IDEX,
  output logic             Stall_EXMEM,
  output logic             Flush_IFID,
  output logic             Flush_IDEX,
  output logic             Flush_EXMEM,
  output logic             Flush_MEMWB,
  output logic [1:0]       CtrlState,
  output logic [CNT_W-1:0] StallCount,
  output logic             MemTimeoutErr
);

  localparam int unsigned WC_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WC_W-1:0]  WC_ZERO     = WC_W'(0);
  localparam logic [WC_W-1:0]  WC_ONE      = WC_W'(1);
  localparam logic [WC_W-1:0]  WC_TIMEOUT  = WC_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_MD_WAIT  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [WC_W-1:0] r_wait_cnt;
  logic [WC_W-1:0] w_next_wait_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic            r_timeout_err;
  logic            w_set_err;
  logic            w_lu;
  logic            w_run_eval;
  logic            w_allow_mem;
  logic            w_allow_md;
  logic            w_stall_pc, w_stall_ifid, w_stall_idex, w_stall_exmem;
  logic            w_flush_ifid, w_flush_idex, w_flush_exmem, w_flush_memwb;

  // Load-use: ID reads a register that the load in EX has not produced yet.
  assign w_lu = MemRead_EX && (WriteRegAddr_EX != 5'd0) &&
                ((UsesRs_ID && (Rs_ID == WriteRegAddr_EX)) ||
                 (UsesRt_ID && (Rt_ID == WriteRegAddr_EX)));

  // Next-state, wait counter and raw stall/flush decode.
  always_comb begin
    w_next_state    = r_state;
    w_next_wait_cnt = r_wait_cnt;
    w_set_err       = 1'b0;
    w_run_eval      = 1'b0;
    w_allow_mem     = 1'b0;
    w_allow_md      = 1'b0;
    w_stall_pc      = 1'b0;
    w_stall_ifid    = 1'b0;
    w_stall_idex    = 1'b0;
    w_stall_exmem   = 1'b0;
    w_flush_ifid    = 1'b0;
    w_flush_idex    = 1'b0;
    w_flush_exmem   = 1'b0;
    w_flush_memwb   = 1'b0;

    case (r_state)
      ST_RUN: begin
        w_run_eval  = 1'b1;
        w_allow_mem = 1'b1;
        w_allow_md  = 1'b1;
      end
      ST_MEM_WAIT: begin
        if (!MemReady) begin
          if (r_wait_cnt == WC_TIMEOUT) begin
            // Give up: drop the access, drain it as a bubble and resume.
            w_flush_memwb   = 1'b1;
            w_set_err       = 1'b1;
            w_next_state    = ST_RUN;
            w_next_wait_cnt = WC_ZERO;
          end else begin
            w_stall_pc      = 1'b1;
            w_stall_ifid    = 1'b1;
            w_stall_idex    = 1'b1;
            w_stall_exmem   = 1'b1;
            w_flush_memwb   = 1'b1;
            w_next_wait_cnt = r_wait_cnt + WC_ONE;
          end
        end else begin
          w_run_eval      = 1'b1;
          w_allow_mem     = 1'b0;
          w_allow_md      = 1'b1;
          w_next_wait_cnt = WC_ZERO;
        end
      end
      ST_MD_WAIT: begin
        if (!MulDivDone) begin
          // MEM holds a bubble here, so a memory request is not possible.
          w_stall_pc    = 1'b1;
          w_stall_ifid  = 1'b1;
          w_stall_idex  = 1'b1;
          w_flush_exmem = 1'b1;
        end else begin
          w_run_eval   = 1'b1;
          w_allow_mem  = 1'b0;
          w_allow_md   = 1'b0;
          w_next_state = ST_RUN;
        end
      end
      default: begin
        w_next_state    = ST_RUN;
        w_next_wait_cnt = WC_ZERO;
      end
    endcase

    if (w_run_eval) begin
      if (w_allow_mem && MemReq_MEM && !MemReady) begin
        w_stall_pc      = 1'b1;
        w_stall_ifid    = 1'b1;
        w_stall_idex    = 1'b1;
        w_stall_exmem   = 1'b1;
        w_flush_memwb   = 1'b1;
        w_next_state    = ST_MEM_WAIT;
        w_next_wait_cnt = WC_ONE;
      end else if (w_allow_md && MulDivStart_EX && !MulDivDone) begin
        w_stall_pc    = 1'b1;
        w_stall_ifid  = 1'b1;
        w_stall_idex  = 1'b1;
        w_flush_exmem = 1'b1;
        w_next_state  = ST_MD_WAIT;
      end else if (BranchTaken_EX) begin
        // The dependent instruction is squashed, so load-use is moot.
        w_flush_ifid = 1'b1;
        w_flush_idex = 1'b1;
        w_next_state = ST_RUN;
      end else if (w_lu) begin
        w_stall_pc   = 1'b1;
        w_stall_ifid = 1'b1;
        w_flush_idex = 1'b1;
        w_next_state = ST_RUN;
      end else begin
        w_next_state = ST_RUN;
      end
    end else begin
      w_next_state = w_next_state;
    end
  end

  // Reset forces bubbles everywhere; a held register is never also flushed.
  assign Stall_PC    = reset_n & w_stall_pc;
  assign Stall_IFID  = reset_n & w_stall_ifid;
  assign Stall_IDEX  = reset_n & w_stall_idex;
  assign Stall_EXMEM = reset_n & w_stall_exmem;
  assign Flush_IFID  = ~reset_n | (w_flush_ifid  & ~w_stall_ifid);
  assign Flush_IDEX  = ~reset_n | (w_flush_idex  & ~w_stall_idex);
  assign Flush_EXMEM = ~reset_n | (w_flush_exmem & ~w_stall_exmem);
  assign Flush_MEMWB = ~reset_n | w_flush_memwb;

  assign CtrlState     = r_state;
  assign StallCount    = r_stall_cnt;
  assign MemTimeoutErr = r_timeout_err;

  // Control state and memory wait counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_RUN;
      r_wait_cnt <= WC_ZERO;
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= w_next_wait_cnt;
    end
  end

  // Saturating count of cycles in which the PC is held.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cnt <= CNT_ZERO;
    end else if (Stall_PC && (r_stall_cnt != CNT_MAX)) begin
      r_stall_cnt <= r_stall_cnt + CNT_ONE;
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end

  // Sticky memory-timeout flag, cleared only by reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_timeout_err <= 1'b0;
    end else if (w_set_err) begin
      r_timeout_err <= 1'b1;
    end else begin
      r_timeout_err <= r_timeout_err;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (MEM_TIMEOUT=8).
module tb_pipeline_hazard_ctrl;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        MemRead_EX, UsesRs_ID, UsesRt_ID, BranchTaken_EX;
  logic        MemReq_MEM, MemReady, MulDivStart_EX, MulDivDone;
  logic [4:0]  WriteRegAddr_EX, Rs_ID, Rt_ID;
  logic        Stall_PC, Stall_IFID, Stall_IDEX, Stall_EXMEM;
  logic        Flush_IFID, Flush_IDEX, Flush_EXMEM, Flush_MEMWB;
  logic [1:0]  CtrlState;
  logic [31:0] StallCount;
  logic        MemTimeoutErr;

  logic [3:0]  stall_v, flush_v;
  int          tests_run = 0;
  int          tests_failed = 0;
  logic [31:0] exp_cnt;

  assign stall_v = {Stall_PC, Stall_IFID, Stall_IDEX, Stall_EXMEM};
  assign flush_v = {Flush_IFID, Flush_IDEX, Flush_EXMEM, Flush_MEMWB};

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(8), .CNT_W(32)) dut (
    .clock(clock), .reset_n(reset_n),
    .MemRead_EX(MemRead_EX), .WriteRegAddr_EX(WriteRegAddr_EX),
    .Rs_ID(Rs_ID), .Rt_ID(Rt_ID), .UsesRs_ID(UsesRs_ID), .UsesRt_ID(UsesRt_ID),
    .BranchTaken_EX(BranchTaken_EX), .MemReq_MEM(MemReq_MEM), .MemReady(MemReady),
    .MulDivStart_EX(MulDivStart_EX), .MulDivDone(MulDivDone),
    .Stall_PC(Stall_PC), .Stall_IFID(Stall_IFID), .Stall_IDEX(Stall_IDEX),
    .Stall_EXMEM(Stall_EXMEM), .Flush_IFID(Flush_IFID), .Flush_IDEX(Flush_IDEX),
    .Flush_EXMEM(Flush_EXMEM), .Flush_MEMWB(Flush_MEMWB), .CtrlState(CtrlState),
    .StallCount(StallCount), .MemTimeoutErr(MemTimeoutErr)
  );

  // Free-running pipeline clock.
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    MemRead_EX = 1'b0; WriteRegAddr_EX = 5'd0; Rs_ID = 5'd0; Rt_ID = 5'd0;
    UsesRs_ID = 1'b0; UsesRt_ID = 1'b0; BranchTaken_EX = 1'b0;
    MemReq_MEM = 1'b0; MemReady = 1'b0; MulDivStart_EX = 1'b0; MulDivDone = 1'b0;
  endtask

  task automatic set_lu(input logic [4:0] wr, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt);
    MemRead_EX = 1'b1; WriteRegAddr_EX = wr; Rs_ID = rs; Rt_ID = rt;
    UsesRs_ID = urs; UsesRt_ID = urt;
  endtask

  initial begin
    clear_inputs();
    exp_cnt = 32'd0;
    #1 reset_n = 1'b0;

    // Reset with a pending memory request: bubbles only, no stalls.
    MemReq_MEM = 1'b1;
    repeat (3) tick();
    check_eq("rst_stall", {28'd0, stall_v}, 32'h0);
    check_eq("rst_flush", {28'd0, flush_v}, 32'hF);
    check_eq("rst_state", {30'd0, CtrlState}, 32'd0);
    check_eq("rst_cnt", StallCount, 32'd0);
    check_eq("rst_err", {31'd0, MemTimeoutErr}, 32'd0);
    MemReq_MEM = 1'b0;
    reset_n = 1'b1;
    #1;
    check_eq("post_rst_stall", {28'd0, stall_v}, 32'h0);
    check_eq("post_rst_flush", {28'd0, flush_v}, 32'h0);
    tick();

    // Load-use on rs: one bubble cycle.
    set_lu(5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
    #1;
    check_eq("lu_rs_stall", {28'd0, stall_v}, 32'hC);
    check_eq("lu_rs_flush", {28'd0, flush_v}, 32'h4);
    tick();
    exp_cnt = exp_cnt + 32'd1;
    clear_inputs();
    #1;
    check_eq("lu_rs_after_stall", {28'd0, stall_v}, 32'h0);
    check_eq("lu_rs_cnt", StallCount, exp_cnt);

    // Load to r0 never creates a hazard.
    set_lu(5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
    #1;
    check_eq("lu_r0_stall", {28'd0, stall_v}, 32'h0);
    check_eq("lu_r0_flush", {28'd0, flush_v}, 32'h0);
    tick();

    // Load-use on rt.
    set_lu(5'd7, 5'd3, 5'd7, 1'b1, 1'b1);
    #1;
    check_eq("lu_rt_stall", {28'd0, stall_v}, 32'hC);
    tick();
    exp_cnt = exp_cnt + 32'd1;

    // Matching register but not read: no hazard.
    set_lu(5'd9, 5'd9, 5'd1, 1'b0, 1'b1);
    #1;
    check_eq("lu_unused_stall", {28'd0, stall_v}, 32'h0);
    tick();

    // Taken branch overrides load-use.
    set_lu(5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
    BranchTaken_EX = 1'b1;
    #1;
    check_eq("br_lu_stall", {28'd0, stall_v}, 32'h0);
    check_eq("br_lu_flush", {28'd0, flush_v}, 32'hC);
    tick();
    clear_inputs();
    #1;
    check_eq("br_cnt", StallCount, exp_cnt);

    // Memory wait: four stalled cycles then ready.
    MemReq_MEM = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq($sformatf("mw_stall_%0d", i), {28'd0, stall_v}, 32'hF);
      check_eq($sformatf("mw_flush_%0d", i), {28'd0, flush_v}, 32'h1);
      check_eq($sformatf("mw_state_%0d", i), {30'd0, CtrlState}, (i == 0) ? 32'd0 : 32'd1);
      tick();
      exp_cnt = exp_cnt + 32'd1;
    end
    MemReady = 1'b1;
    #1;
    check_eq("mw_rel_state", {30'd0, CtrlState}, 32'd1);
    check_eq("mw_rel_stall", {28'd0, stall_v}, 32'h0);
    check_eq("mw_rel_flush", {28'd0, flush_v}, 32'h0);
    tick();
    clear_inputs();
    #1;
    check_eq("mw_end_state", {30'd0, CtrlState}, 32'd0);
    check_eq("mw_cnt", StallCount, exp_cnt);

    // Mul/div: six stalled cycles, done arrives with a taken branch.
    MulDivStart_EX = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 1) MulDivStart_EX = 1'b0;
      MemReq_MEM = (i == 3);
      #1;
      check_eq($sformatf("md_stall_%0d", i), {28'd0, stall_v}, 32'hE);
      check_eq($sformatf("md_flush_%0d", i), {28'd0, flush_v}, 32'h2);
      check_eq($sformatf("md_state_%0d", i), {30'd0, CtrlState}, (i == 0) ? 32'd0 : 32'd2);
      tick();
      exp_cnt = exp_cnt + 32'd1;
    end
    MemReq_MEM = 1'b0;
    MulDivDone = 1'b1;
    BranchTaken_EX = 1'b1;
    #1;
    check_eq("md_done_stall", {28'd0, stall_v}, 32'h0);
    check_eq("md_done_flush", {28'd0, flush_v}, 32'hC);
    tick();
    clear_inputs();
    #1;
    check_eq("md_end_state", {30'd0, CtrlState}, 32'd0);
    check_eq("md_cnt", StallCount, exp_cnt);

    // Start and done together: zero-wait.
    MulDivStart_EX = 1'b1;
    MulDivDone = 1'b1;
    #1;
    check_eq("md0_stall", {28'd0, stall_v}, 32'h0);
    check_eq("md0_flush", {28'd0, flush_v}, 32'h0);
    tick();
    clear_inputs();
    #1;
    check_eq("md0_state", {30'd0, CtrlState}, 32'd0);

    // Reset in the middle of MD_WAIT aborts immediately.
    MulDivStart_EX = 1'b1;
    tick();
    MulDivStart_EX = 1'b0;
    #1;
    check_eq("mdrst_wait_state", {30'd0, CtrlState}, 32'd2);
    reset_n = 1'b0;
    #1;
    check_eq("mdrst_state", {30'd0, CtrlState}, 32'd0);
    check_eq("mdrst_stall", {28'd0, stall_v}, 32'h0);
    check_eq("mdrst_flush", {28'd0, flush_v}, 32'hF);
    check_eq("mdrst_cnt", StallCount, 32'd0);
    exp_cnt = 32'd0;
    tick();
    reset_n = 1'b1;
    clear_inputs();
    tick();

    // Memory timeout: eight stalled cycles, then abort.
    MemReq_MEM = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      check_eq($sformatf("to_stall_%0d", i), {28'd0, stall_v}, 32'hF);
      tick();
      exp_cnt = exp_cnt + 32'd1;
    end
    #1;
    check_eq("to_abort_stall", {28'd0, stall_v}, 32'h0);
    check_eq("to_abort_flush", {28'd0, flush_v}, 32'h1);
    check_eq("to_abort_err_pre", {31'd0, MemTimeoutErr}, 32'd0);
    tick();
    MemReq_MEM = 1'b0;
    #1;
    check_eq("to_err", {31'd0, MemTimeoutErr}, 32'd1);
    check_eq("to_state", {30'd0, CtrlState}, 32'd0);
    check_eq("to_cnt", StallCount, exp_cnt);
    repeat (3) tick();
    check_eq("to_err_sticky", {31'd0, MemTimeoutErr}, 32'd1);
    check_eq("to_after_stall", {28'd0, stall_v}, 32'h0);
    reset_n = 1'b0;
    #1;
    check_eq("to_err_clr", {31'd0, MemTimeoutErr}, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush scheduler for the 5-stage pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB registers).
- Detects load-use hazards, taken-branch redirects, multi-cycle memory waits and multi-cycle mul/div ops.
- Drives per-register hold (stall) and bubble (flush) controls, and keeps a stall performance counter and a memory-timeout error flag.

Parameters:
- MEM_TIMEOUT, 64: max consecutive MEM_WAIT cycles before error abort; must be ≥2.
- CNT_W, 32: width of the stall-cycle counter.

Ports:
- clock  in  1  single pipeline clock, rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- MemRead_EX  in  1  instruction in EX is a load.
- WriteRegAddr_EX  in  5  destination register of the EX instruction.
- Rs_ID  in  5  source register rs of the ID instruction.
- Rt_ID  in  5  source register rt of the ID instruction.
- UsesRs_ID  in  1  ID instruction reads rs.
- UsesRt_ID  in  1  ID instruction reads rt.
- BranchTaken_EX  in  1  branch/jump resolved taken in EX.
- MemReq_MEM  in  1  MEM-stage instruction accesses data memory.
- MemReady  in  1  data memory completes access this cycle.
- MulDivStart_EX  in  1  multi-cycle mul/div op in EX, first cycle.
- MulDivDone  in  1  mul/div result valid this cycle.
- Stall_PC  out  1  hold PC.
- Stall_IFID  out  1  hold IF/ID register.
- Stall_IDEX  out  1  hold ID/EX register.
- Stall_EXMEM  out  1  hold EX/MEM register.
- Flush_IFID  out  1  load bubble into IF/ID.
- Flush_IDEX  out  1  load bubble into ID/EX.
- Flush_EXMEM  out  1  load bubble into EX/MEM.
- Flush_MEMWB  out  1  load bubble into MEM/WB (RegWrite_WB=0).
- CtrlState  out  2  0=RUN, 1=MEM_WAIT, 2=MD_WAIT.
- StallCount  out  CNT_W  saturating count of cycles with Stall_PC=1.
- MemTimeoutErr  out  1  sticky; set on memory timeout.

Behaviour:
- Stall/flush outputs are combinational from state and inputs. State, wait counter, StallCount and MemTimeoutErr are registered.
- Reset (reset_n low, asynchronous):
  - CtrlState=RUN, wait counter=0, StallCount=0, MemTimeoutErr=0.
  - All Stall_* =0; all Flush_* =1 while reset_n low, so the pipeline fills with bubbles.
  - Reset asserted in MEM_WAIT or MD_WAIT aborts the wait immediately.
- Load-use hazard (LU) = MemRead_EX && WriteRegAddr_EX≠0 && ((UsesRs_ID && Rs_ID==WriteRegAddr_EX) || (UsesRt_ID && Rt_ID==WriteRegAddr_EX)).
- RUN, evaluated in strict priority order, first match wins:
  1. MemReq_MEM && !MemReady:
     - Stall_PC, Stall_IFID, Stall_IDEX, Stall_EXMEM =1; Flush_MEMWB=1; next MEM_WAIT.
     - Wait counter loads 1.
  2. MulDivStart_EX && !MulDivDone:
     - Stall_PC, Stall_IFID, Stall_IDEX =1; Flush_EXMEM=1; next MD_WAIT.
     - MulDivStart_EX with MulDivDone in the same cycle is zero-wait: no stall, fall through.
  3. BranchTaken_EX:
     - Flush_IFID=1, Flush_IDEX=1, no stalls.
     - Overrides LU, because the dependent instruction is squashed.
  4. LU: Stall_PC=1, Stall_IFID=1, Flush_IDEX=1 (one-cycle bubble).
  5. Otherwise all outputs 0.
- MEM_WAIT:
  - While !MemReady: same outputs as RUN case 1; wait counter increments each cycle.
  - MemReady=1: release; outputs and next state computed exactly as RUN with case 1 suppressed. Wait counter resets to 0.
  - Wait counter reaches MEM_TIMEOUT with MemReady still 0: set MemTimeoutErr, assert Flush_MEMWB, drop all stalls, next RUN. The faulting access is discarded.
- MD_WAIT:
  - While !MulDivDone: Stall_PC, Stall_IFID, Stall_IDEX =1; Flush_EXMEM=1; EX/MEM and MEM/WB drain normally.
  - MemReq_MEM is ignored, since the MEM stage holds a bubble after the first cycle.
  - MulDivDone=1: stalls released in that cycle, next RUN. BranchTaken_EX and LU are evaluated as in RUN cases 3–4.
- Any stall asserted never coexists with a flush of the same register; stall wins.
- StallCount increments on every cycle with Stall_PC=1 and saturates at all-ones (no wrap).
- MemTimeoutErr clears only on reset.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles with MemReq_MEM=1 → all Flush_*=1, Stall_*=0, CtrlState=0, StallCount=0; release → all outputs 0.
- Load-use: MemRead_EX=1, WriteRegAddr_EX=5, Rs_ID=5, UsesRs_ID=1 for one cycle → Stall_PC=Stall_IFID=Flush_IDEX=1 that cycle only, StallCount=1. Repeat with WriteRegAddr_EX=0 → no stall.
- Branch vs load-use: LU condition and BranchTaken_EX=1 together → Flush_IFID=Flush_IDEX=1, Stall_PC=0.
- Memory wait: MemReq_MEM=1 with MemReady low for 4 cycles, high on the 5th → four cycles of all stalls plus Flush_MEMWB, CtrlState=1, then RUN; StallCount=4.
- Timeout (MEM_TIMEOUT=8): MemReady held 0 → after 8 wait cycles MemTimeoutErr=1, stalls drop, CtrlState=0; MemTimeoutErr stays 1 until reset.
- Mul/div: MulDivStart_EX=1, MulDivDone after 6 cycles → Stall_PC/IFID/IDEX plus Flush_EXMEM for 6 cycles, CtrlState=2. Start and Done in the same cycle → no stall. Also assert reset mid-MD_WAIT → immediate RUN.
